// File: rtl/atc_pkg.sv
// Shared runway-control definitions: plane ID type, allocation policies,
// reply opcodes and width helpers used by the allocator and reply builder.
package atc_pkg;

   localparam int ID_WIDTH_DEF = 4;
   typedef logic [ID_WIDTH_DEF-1:0] plane_id_t;

   localparam int ALLOC_LOWEST = 0;
   localparam int ALLOC_RR     = 1;

   localparam logic [2:0] REPLY_CLEAR  = 3'b011;
   localparam logic [2:0] REPLY_HOLD   = 3'b100;
   localparam logic [2:0] REPLY_DIVERT = 3'b110;

   function automatic int rwy_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // A disabled timeout still needs a 1-bit timer so the slot stays legal.
   function automatic int timer_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/runway_allocator_if.sv
// Request/result bundle between the request FSM (master) and the runway
// allocator (slave).
interface runway_allocator_if
   import atc_pkg::*;
#(
   parameter int NUM_RUNWAYS = 2,
   parameter int ID_WIDTH    = ID_WIDTH_DEF
);
   localparam int RWY_W = rwy_width(NUM_RUNWAYS);
   localparam int CNT_W = $clog2(NUM_RUNWAYS + 1);

   logic                   alloc_req;
   logic [ID_WIDTH-1:0]    alloc_plane_id;
   logic                   alloc_grant;
   logic                   alloc_deny;
   logic [RWY_W-1:0]       alloc_runway_id;
   logic                   release_req;
   logic [RWY_W-1:0]       release_runway_id;
   logic [ID_WIDTH-1:0]    release_plane_id;
   logic                   release_ok;
   logic                   release_err;
   logic [NUM_RUNWAYS-1:0] runway_close;
   logic [NUM_RUNWAYS-1:0] runway_active;
   logic [NUM_RUNWAYS-1:0] runway_overdue;
   logic                   overdue_pulse;
   logic [CNT_W-1:0]       busy_count;

   modport master (
      output alloc_req, alloc_plane_id, release_req, release_runway_id,
             release_plane_id, runway_close,
      input  alloc_grant, alloc_deny, alloc_runway_id, release_ok, release_err,
             runway_active, runway_overdue, overdue_pulse, busy_count
   );

   modport slave (
      input  alloc_req, alloc_plane_id, release_req, release_runway_id,
             release_plane_id, runway_close,
      output alloc_grant, alloc_deny, alloc_runway_id, release_ok, release_err,
             runway_active, runway_overdue, overdue_pulse, busy_count
   );

endinterface

// File: rtl/runway_allocator_slot.sv
// One runway: occupant ID, active bit, saturating occupancy timer and sticky
// overdue flag, plus the release ID compare.
module runway_slot
   import atc_pkg::*;
#(
   parameter int ID_WIDTH       = ID_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                grant,
   input  logic [ID_WIDTH-1:0] grant_id,
   input  logic                release_acc,
   input  logic [ID_WIDTH-1:0] rel_id,
   output logic                active,
   output logic                overdue,
   output logic                rel_match,
   output logic                overdue_set
);
   localparam int            TW     = timer_width(TIMEOUT_CYCLES);
   localparam bit            T_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [ID_WIDTH-1:0] occ_q, occ_d;
   logic                active_q, active_d;
   logic                overdue_q, overdue_d;
   logic [TW-1:0]       timer_q, timer_d;

   assign active    = active_q;
   assign overdue   = overdue_q;
   assign rel_match = active_q && (occ_q == rel_id);

   always_comb begin
      overdue_set = T_EN && active_q && !release_acc && (timer_q == T_LAST);
      occ_d       = grant ? grant_id : occ_q;
      active_d    = (active_q | grant) & ~release_acc;
      timer_d     = timer_q;
      overdue_d   = overdue_q;
      if (grant || release_acc) begin
         timer_d   = '0;
         overdue_d = 1'b0;
      end else begin
         if (T_EN && active_q && (timer_q != T_MAX)) timer_d = timer_q + 1'b1;
         if (overdue_set) overdue_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occ_q     <= '0;
         active_q  <= 1'b0;
         overdue_q <= 1'b0;
         timer_q   <= '0;
      end else begin
         occ_q     <= occ_d;
         active_q  <= active_d;
         overdue_q <= overdue_d;
         timer_q   <= timer_d;
      end
   end

endmodule

// File: rtl/runway_allocator.sv
// Runway allocator top: lowest-first or round-robin arbitration over
// NUM_RUNWAYS slots, release checking, occupancy popcount and overdue pulse.
module runway_allocator
   import atc_pkg::*;
#(
   parameter int NUM_RUNWAYS    = 2,
   parameter int ID_WIDTH       = ID_WIDTH_DEF,
   parameter int ALLOC_MODE     = ALLOC_LOWEST,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic               clock,
   input logic               reset,
   runway_allocator_if.slave bus
);
   localparam int RWY_W = rwy_width(NUM_RUNWAYS);
   localparam int CNT_W = $clog2(NUM_RUNWAYS + 1);

   logic [NUM_RUNWAYS-1:0] active, overdue, rel_match, ovd_set;
   logic [NUM_RUNWAYS-1:0] elig, grant_vec, rel_hit, active_nxt;
   logic                   found;
   logic [RWY_W-1:0]       sel, idx_w;
   int                     idx;

   logic                   grant_q, grant_d, deny_q, deny_d;
   logic                   ok_q, ok_d, err_q, err_d, pulse_q, pulse_d;
   logic [RWY_W-1:0]       id_q, id_d, ptr_q, ptr_d;
   logic [CNT_W-1:0]       busy_q, busy_d;

   for (genvar i = 0; i < NUM_RUNWAYS; i++) begin : g_slot
      runway_slot #(
         .ID_WIDTH       (ID_WIDTH),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_slot (
         .clock       (clock),
         .reset       (reset),
         .grant       (grant_vec[i]),
         .grant_id    (bus.alloc_plane_id),
         .release_acc (rel_hit[i]),
         .rel_id      (bus.release_plane_id),
         .active      (active[i]),
         .overdue     (overdue[i]),
         .rel_match   (rel_match[i]),
         .overdue_set (ovd_set[i])
      );
   end

   always_comb begin
      // A runway being released this cycle is still active here, so it is
      // naturally excluded from this cycle's allocation.
      elig  = ~active & ~bus.runway_close;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      idx_w = '0;
      for (int k = 0; k < NUM_RUNWAYS; k++) begin
         idx   = (ALLOC_MODE == ALLOC_RR) ? (int'(ptr_q) + 1 + k) % NUM_RUNWAYS : k;
         idx_w = RWY_W'(idx);
         if (!found && elig[idx_w]) begin
            found = 1'b1;
            sel   = idx_w;
         end
      end

      grant_vec = '0;
      rel_hit   = '0;
      for (int i = 0; i < NUM_RUNWAYS; i++) begin
         grant_vec[i] = bus.alloc_req && found && (sel == RWY_W'(i));
         rel_hit[i]   = bus.release_req && (bus.release_runway_id == RWY_W'(i)) && rel_match[i];
      end
      active_nxt = (active | grant_vec) & ~rel_hit;

      busy_d = '0;
      for (int i = 0; i < NUM_RUNWAYS; i++) busy_d = busy_d + CNT_W'(active_nxt[i]);

      grant_d = bus.alloc_req && found;
      deny_d  = bus.alloc_req && !found;
      id_d    = grant_d ? sel : id_q;
      ptr_d   = grant_d ? sel : ptr_q;
      ok_d    = |rel_hit;
      err_d   = bus.release_req && !(|rel_hit);
      pulse_d = |ovd_set;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant_q <= 1'b0;
         deny_q  <= 1'b0;
         id_q    <= '0;
         ptr_q   <= RWY_W'(NUM_RUNWAYS - 1);
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         pulse_q <= 1'b0;
         busy_q  <= '0;
      end else begin
         grant_q <= grant_d;
         deny_q  <= deny_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.alloc_grant     = grant_q;
   assign bus.alloc_deny      = deny_q;
   assign bus.alloc_runway_id = id_q;
   assign bus.release_ok      = ok_q;
   assign bus.release_err     = err_q;
   assign bus.runway_active   = active;
   assign bus.runway_overdue  = overdue;
   assign bus.overdue_pulse   = pulse_q;
   assign bus.busy_count      = busy_q;

endmodule

// File: tb/tb_runway_allocator.sv
// Directed bench: three allocator configurations (2-runway lowest-first,
// 4-runway round-robin, 2-runway with an 8-cycle timeout).
module tb_runway_allocator;
   import atc_pkg::*;

   logic clk = 1'b0;
   logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   runway_allocator_if #(.NUM_RUNWAYS(2), .ID_WIDTH(4)) if0 ();
   runway_allocator_if #(.NUM_RUNWAYS(4), .ID_WIDTH(4)) if1 ();
   runway_allocator_if #(.NUM_RUNWAYS(2), .ID_WIDTH(4)) if2 ();

   runway_allocator #(.NUM_RUNWAYS(2), .ID_WIDTH(4), .ALLOC_MODE(ALLOC_LOWEST), .TIMEOUT_CYCLES(1024))
      u0 (.clock(clk), .reset(rst0), .bus(if0));
   runway_allocator #(.NUM_RUNWAYS(4), .ID_WIDTH(4), .ALLOC_MODE(ALLOC_RR), .TIMEOUT_CYCLES(1024))
      u1 (.clock(clk), .reset(rst1), .bus(if1));
   runway_allocator #(.NUM_RUNWAYS(2), .ID_WIDTH(4), .ALLOC_MODE(ALLOC_LOWEST), .TIMEOUT_CYCLES(8))
      u2 (.clock(clk), .reset(rst2), .bus(if2));

   always @(posedge clk) begin
      if (!rst0) assert (!$isunknown({if0.alloc_req, if0.release_req})) else $error("X on if0 request");
      if (!rst1) assert (!$isunknown({if1.alloc_req, if1.release_req})) else $error("X on if1 request");
      if (!rst2) assert (!$isunknown({if2.alloc_req, if2.release_req})) else $error("X on if2 request");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic a, input logic [3:0] aid, input logic r,
                         input logic rw, input logic [3:0] rid);
      if0.alloc_req = a; if0.alloc_plane_id = aid;
      if0.release_req = r; if0.release_runway_id = rw; if0.release_plane_id = rid;
      tick();
      if0.alloc_req = 1'b0; if0.release_req = 1'b0;
   endtask

   task automatic drive1(input logic a, input logic [3:0] aid, input logic r,
                         input logic [1:0] rw, input logic [3:0] rid);
      if1.alloc_req = a; if1.alloc_plane_id = aid;
      if1.release_req = r; if1.release_runway_id = rw; if1.release_plane_id = rid;
      tick();
      if1.alloc_req = 1'b0; if1.release_req = 1'b0;
   endtask

   task automatic drive2(input logic a, input logic [3:0] aid, input logic r,
                         input logic rw, input logic [3:0] rid);
      if2.alloc_req = a; if2.alloc_plane_id = aid;
      if2.release_req = r; if2.release_runway_id = rw; if2.release_plane_id = rid;
      tick();
      if2.alloc_req = 1'b0; if2.release_req = 1'b0;
   endtask

   initial begin
      if0.alloc_req = 1'b0; if0.alloc_plane_id = '0; if0.release_req = 1'b0;
      if0.release_runway_id = '0; if0.release_plane_id = '0; if0.runway_close = '0;
      if1.alloc_req = 1'b0; if1.alloc_plane_id = '0; if1.release_req = 1'b0;
      if1.release_runway_id = '0; if1.release_plane_id = '0; if1.runway_close = '0;
      if2.alloc_req = 1'b0; if2.alloc_plane_id = '0; if2.release_req = 1'b0;
      if2.release_runway_id = '0; if2.release_plane_id = '0; if2.runway_close = '0;
      tick();
      tick();
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      tick();

      // reset state
      check("rst_grant",  32'(if0.alloc_grant), 0);
      check("rst_deny",   32'(if0.alloc_deny), 0);
      check("rst_ok",     32'(if0.release_ok), 0);
      check("rst_err",    32'(if0.release_err), 0);
      check("rst_active", 32'(if0.runway_active), 0);
      check("rst_ovd",    32'(if0.runway_overdue), 0);
      check("rst_pulse",  32'(if0.overdue_pulse), 0);
      check("rst_busy",   32'(if0.busy_count), 0);
      check("rst_rid",    32'(if0.alloc_runway_id), 0);
      check("rst_busy1",  32'(if1.busy_count), 0);

      // lowest-first fill and deny
      drive0(1, 4'h3, 0, 0, 4'h0);
      check("t1_grant0", 32'(if0.alloc_grant), 1);
      check("t1_rid0",   32'(if0.alloc_runway_id), 0);
      check("t1_busy1",  32'(if0.busy_count), 1);
      drive0(1, 4'h5, 0, 0, 4'h0);
      check("t1_grant1", 32'(if0.alloc_grant), 1);
      check("t1_rid1",   32'(if0.alloc_runway_id), 1);
      check("t1_busy2",  32'(if0.busy_count), 2);
      drive0(1, 4'h7, 0, 0, 4'h0);
      check("t1_deny",   32'(if0.alloc_deny), 1);
      check("t1_nogrant",32'(if0.alloc_grant), 0);
      check("t1_active", 32'(if0.runway_active), 2'b11);
      check("t1_ridhold",32'(if0.alloc_runway_id), 1);

      // simultaneous release + alloc: released runway not eligible same cycle
      drive0(1, 4'h9, 1, 0, 4'h3);
      check("t4_ok",     32'(if0.release_ok), 1);
      check("t4_deny",   32'(if0.alloc_deny), 1);
      check("t4_active", 32'(if0.runway_active), 2'b10);
      check("t4_busy",   32'(if0.busy_count), 1);
      drive0(1, 4'h9, 0, 0, 4'h0);
      check("t4_regrant",32'(if0.alloc_grant), 1);
      check("t4_rid",    32'(if0.alloc_runway_id), 0);
      check("t4_busy2",  32'(if0.busy_count), 2);

      // release ID checking on runway 1 held by plane 7
      drive0(0, 4'h0, 1, 1, 4'h5);
      check("t3_prep_ok",32'(if0.release_ok), 1);
      drive0(1, 4'h7, 0, 0, 4'h0);
      check("t3_rid1",   32'(if0.alloc_runway_id), 1);
      drive0(0, 4'h0, 1, 1, 4'h2);
      check("t3_bad_err",32'(if0.release_err), 1);
      check("t3_bad_ok", 32'(if0.release_ok), 0);
      check("t3_bad_act",32'(if0.runway_active), 2'b11);
      drive0(0, 4'h0, 1, 1, 4'h7);
      check("t3_good_ok",32'(if0.release_ok), 1);
      check("t3_good_act",32'(if0.runway_active), 2'b01);
      check("t3_good_busy",32'(if0.busy_count), 1);
      drive0(0, 4'h0, 1, 1, 4'h7);
      check("t3_again_err",32'(if0.release_err), 1);
      check("t3_again_act",32'(if0.runway_active), 2'b01);
      drive0(0, 4'h0, 1, 0, 4'h9);
      check("t3_clr_act",32'(if0.runway_active), 0);

      // closure
      if0.runway_close = 2'b01;
      drive0(1, 4'h4, 0, 0, 4'h0);
      check("t5_rid",    32'(if0.alloc_runway_id), 1);
      check("t5_act",    32'(if0.runway_active), 2'b10);
      if0.runway_close = 2'b11;
      drive0(0, 4'h0, 0, 0, 4'h0);
      check("t5_keep",   32'(if0.runway_active), 2'b10);
      check("t5_pulse0", 32'(if0.alloc_grant), 0);
      drive0(1, 4'h6, 0, 0, 4'h0);
      check("t5_deny",   32'(if0.alloc_deny), 1);
      drive0(0, 4'h0, 1, 1, 4'h4);
      check("t5_rel_ok", 32'(if0.release_ok), 1);
      check("t5_rel_act",32'(if0.runway_active), 0);
      if0.runway_close = 2'b00;
      drive0(1, 4'h6, 0, 0, 4'h0);
      check("t5_reopen", 32'(if0.alloc_runway_id), 0);
      check("t5_reopen_g",32'(if0.alloc_grant), 1);

      // round-robin, each grant released the cycle after it issues
      for (int k = 0; k < 5; k++) begin
         drive1(1, 4'(k + 1), 0, 2'd0, 4'h0);
         check($sformatf("t2_grant%0d", k), 32'(if1.alloc_grant), 1);
         check($sformatf("t2_rid%0d", k),   32'(if1.alloc_runway_id), 32'(k % 4));
         drive1(0, 4'h0, 1, 2'(k % 4), 4'(k + 1));
         check($sformatf("t2_rel%0d", k),   32'(if1.release_ok), 1);
      end
      check("t2_busy", 32'(if1.busy_count), 0);

      // overdue timing
      drive2(1, 4'h1, 0, 0, 4'h0);
      check("t6_grant", 32'(if2.alloc_grant), 1);
      for (int c = 1; c < 8; c++) begin
         tick();
         check($sformatf("t6_early%0d", c), 32'(if2.overdue_pulse), 0);
      end
      tick();
      check("t6_pulse",  32'(if2.overdue_pulse), 1);
      check("t6_ovd",    32'(if2.runway_overdue), 2'b01);
      tick();
      check("t6_pulse_once", 32'(if2.overdue_pulse), 0);
      check("t6_sticky", 32'(if2.runway_overdue), 2'b01);
      drive2(0, 4'h0, 1, 0, 4'h1);
      check("t6_rel_ok", 32'(if2.release_ok), 1);
      check("t6_rel_ovd",32'(if2.runway_overdue), 0);
      check("t6_rel_act",32'(if2.runway_active), 0);

      // asynchronous reset mid-operation
      drive2(1, 4'h2, 0, 0, 4'h0);
      drive2(1, 4'h3, 0, 0, 4'h0);
      check("t6_rid1",   32'(if2.alloc_runway_id), 1);
      for (int c = 0; c < 12; c++) tick();
      check("t6_both_ovd", 32'(if2.runway_overdue), 2'b11);
      check("t6_busy2",  32'(if2.busy_count), 2);
      #2 rst2 = 1'b1;
      #1;
      check("t6_arst_act", 32'(if2.runway_active), 0);
      check("t6_arst_ovd", 32'(if2.runway_overdue), 0);
      check("t6_arst_busy",32'(if2.busy_count), 0);
      check("t6_arst_rid", 32'(if2.alloc_runway_id), 0);
      check("t6_arst_pulse",32'(if2.overdue_pulse), 0);
      @(negedge clk);
      rst2 = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
